// File: rtl/seq_detect_param_if.sv
// Signal bundle for seq_detect_param: serial bit/qualifier/clear in, match flag,
// match count and debug state out.
interface seq_detect_param_if #(
   parameter int unsigned LEN   = 4,
   parameter int unsigned CNT_W = 8
);
   localparam int unsigned SW = $clog2(LEN + 1);

   logic             x;
   logic             en;
   logic             clr_cnt;
   logic             y;
   logic [CNT_W-1:0] count;
   logic [SW-1:0]    state;

   modport master (
      output x,
      output en,
      output clr_cnt,
      input  y,
      input  count,
      input  state
   );

   modport slave (
      input  x,
      input  en,
      input  clr_cnt,
      output y,
      output count,
      output state
   );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector: (LEN+1)-state Moore machine tracking the
// longest matched pattern prefix, with optional overlap and a saturating match count.
module seq_detect_param #(
   parameter int unsigned    LEN     = 4,
   parameter logic [LEN-1:0] PATTERN = 4'b1011,
   parameter bit             OVERLAP = 1'b1,
   parameter int unsigned    CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   seq_detect_param_if.slave  bus
);

   localparam int unsigned SW    = $clog2(LEN + 1);
   localparam int unsigned TAB_N = 2 ** (SW + 1);

   typedef logic [SW-1:0] state_t;

   localparam state_t           S_FULL  = state_t'(LEN);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   if (LEN < 1 || LEN > 16) begin : g_len_chk
      $error("seq_detect_param: LEN must be in 1..16");
   end

   // Longest suffix of (first k pattern bits, then b) that is also a pattern prefix.
   function automatic int calc_next(input int k, input int b);
      logic [16:0] s;
      int          n;
      bit          ok;
      s = '0;
      for (int i = 0; i < 17; i++) begin
         if (i < k) s[i] = PATTERN[LEN-1-i];
      end
      s[k] = b[0];
      n = k + 1;
      for (int j = ((n < int'(LEN)) ? n : int'(LEN)); j > 0; j--) begin
         ok = 1'b1;
         for (int m = 0; m < j; m++) begin
            if (s[n-j+m] != PATTERN[LEN-1-m]) ok = 1'b0;
         end
         if (ok) return j;
      end
      return 0;
   endfunction

   function automatic int next_state(input int k, input int b);
      if (k > int'(LEN)) return 0;
      if (k == int'(LEN) && !OVERLAP) return calc_next(0, b);
      return calc_next(k, b);
   endfunction

   // Transition table indexed by {state, bit}; unreachable states map to S_0.
   state_t nxt_tab [TAB_N];

   for (genvar i = 0; i < TAB_N; i++) begin : g_tab
      localparam int NXT = next_state(i / 2, i % 2);
      assign nxt_tab[i] = state_t'(NXT);
   end

   state_t           state_q;
   state_t           state_d;
   logic             y_q;
   logic [CNT_W-1:0] count_q;
   logic             hit;

   assign state_d = nxt_tab[{state_q, bus.x}];
   assign hit     = bus.en && (state_d == S_FULL);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= '0;
         y_q     <= 1'b0;
         count_q <= '0;
      end else begin
         if (bus.en) begin
            state_q <= state_d;
            y_q     <= (state_d == S_FULL);
         end
         // A match on the clearing edge still counts.
         if (bus.clr_cnt) begin
            count_q <= hit ? CNT_ONE : '0;
         end else if (hit && count_q != CNT_MAX) begin
            count_q <= count_q + CNT_ONE;
         end
      end
   end

   assign bus.y     = y_q;
   assign bus.count = count_q;
   assign bus.state = state_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench: four detector configurations share one random/directed stream
// and are checked against a prefix-matching model over the consumed bit history.
module tb_seq_detect_param;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic x   = 1'b0;
   logic en  = 1'b0;
   logic clr = 1'b0;

   always #5 clk = ~clk;

   seq_detect_param_if #(.LEN(4), .CNT_W(8)) if0 ();
   seq_detect_param_if #(.LEN(4), .CNT_W(8)) if1 ();
   seq_detect_param_if #(.LEN(2), .CNT_W(8)) if2 ();
   seq_detect_param_if #(.LEN(4), .CNT_W(2)) if3 ();

   assign if0.x = x;  assign if0.en = en;  assign if0.clr_cnt = clr;
   assign if1.x = x;  assign if1.en = en;  assign if1.clr_cnt = clr;
   assign if2.x = x;  assign if2.en = en;  assign if2.clr_cnt = clr;
   assign if3.x = x;  assign if3.en = en;  assign if3.clr_cnt = clr;

   seq_detect_param #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_d0 (
      .clk(clk), .rst(rst), .bus(if0));
   seq_detect_param #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_d1 (
      .clk(clk), .rst(rst), .bus(if1));
   seq_detect_param #(.LEN(2), .PATTERN(2'b01), .OVERLAP(1'b1), .CNT_W(8)) u_d2 (
      .clk(clk), .rst(rst), .bus(if2));
   seq_detect_param #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(2)) u_d3 (
      .clk(clk), .rst(rst), .bus(if3));

   typedef struct {
      int y;
      int cnt;
      int st;
   } exp_t;

   int len_c  [4] = '{4, 4, 2, 4};
   int pat_c  [4] = '{11, 11, 1, 11};
   int ov_c   [4] = '{1, 0, 1, 0};
   int cmax_c [4] = '{255, 255, 255, 3};

   bit   hist [4][$];
   int   mk   [4];
   int   mcnt [4];
   exp_t sbq  [4][$];

   int checks = 0;
   int errors = 0;

   // Longest suffix of the consumed history that equals a pattern prefix.
   function automatic int best_k(input int i);
      int n;
      bit ok;
      n = hist[i].size();
      for (int j = (n < len_c[i]) ? n : len_c[i]; j > 0; j--) begin
         ok = 1'b1;
         for (int m = 0; m < j; m++) begin
            if (hist[i][n-j+m] != pat_c[i][len_c[i]-1-m]) ok = 1'b0;
         end
         if (ok) return j;
      end
      return 0;
   endfunction

   task automatic model(input bit r, input bit b, input bit e, input bit c);
      bit   hit;
      exp_t ex;
      for (int i = 0; i < 4; i++) begin
         if (r) begin
            hist[i].delete();
            mk[i]   = 0;
            mcnt[i] = 0;
         end else begin
            hit = 1'b0;
            if (e) begin
               if (mk[i] == len_c[i] && ov_c[i] == 0) hist[i].delete();
               hist[i].push_back(b);
               mk[i] = best_k(i);
               while (hist[i].size() > len_c[i]) void'(hist[i].pop_front());
               hit = (mk[i] == len_c[i]);
            end
            if (c) mcnt[i] = hit ? 1 : 0;
            else if (hit && mcnt[i] < cmax_c[i]) mcnt[i]++;
         end
         ex.y   = (mk[i] == len_c[i]) ? 1 : 0;
         ex.cnt = mcnt[i];
         ex.st  = mk[i];
         sbq[i].push_back(ex);
      end
   endtask

   task automatic step(input bit r, input bit b, input bit e, input bit c);
      @(negedge clk);
      rst = r;
      x   = b;
      en  = e;
      clr = c;
      model(r, b, e, c);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic dchk(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   function automatic exp_t actual(input int i);
      exp_t a;
      case (i)
         0:       begin a.y = int'(if0.y); a.cnt = int'(if0.count); a.st = int'(if0.state); end
         1:       begin a.y = int'(if1.y); a.cnt = int'(if1.count); a.st = int'(if1.state); end
         2:       begin a.y = int'(if2.y); a.cnt = int'(if2.count); a.st = int'(if2.state); end
         default: begin a.y = int'(if3.y); a.cnt = int'(if3.count); a.st = int'(if3.state); end
      endcase
      return a;
   endfunction

   // Monitor: one expected entry per DUT per issued edge, compared just after the edge.
   always @(posedge clk) begin
      exp_t ex;
      exp_t ac;
      #1;
      for (int i = 0; i < 4; i++) begin
         if (sbq[i].size() > 0) begin
            ex = sbq[i].pop_front();
            ac = actual(i);
            checks++;
            if (ac.y !== ex.y || ac.cnt !== ex.cnt || ac.st !== ex.st) begin
               errors++;
               $display("FAIL dut%0d sb @%0t: got y=%0d count=%0d state=%0d, expected y=%0d count=%0d state=%0d",
                        i, $time, ac.y, ac.cnt, ac.st, ex.y, ex.cnt, ex.st);
            end
         end
      end
   end

   int s_main [7] = '{1, 0, 1, 1, 0, 1, 1};
   int s_01   [6] = '{0, 1, 1, 0, 0, 1};
   int s_pat  [4] = '{1, 0, 1, 1};

   initial begin
      int wait_cnt;

      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      settle();
      dchk("reset_y", int'(if0.y), 0);
      dchk("reset_count", int'(if0.count), 0);
      dchk("reset_state", int'(if0.state), 0);

      foreach (s_main[i]) step(0, s_main[i][0], 1, 0);
      settle();
      dchk("ov1_count", int'(if0.count), 2);
      dchk("ov1_state", int'(if0.state), 4);
      dchk("ov0_count", int'(if1.count), 1);
      dchk("ov0_state", int'(if1.state), 1);

      step(1, 0, 0, 0);
      foreach (s_01[i]) step(0, s_01[i][0], 1, 0);
      settle();
      dchk("p01_count", int'(if2.count), 2);
      dchk("p01_y", int'(if2.y), 1);

      step(1, 0, 0, 0);
      foreach (s_pat[i]) begin
         step(0, s_pat[i][0], 1, 0);
         repeat (3) step(0, 1'($urandom_range(1, 0)), 0, 0);
      end
      settle();
      dchk("gap_count", int'(if0.count), 1);
      dchk("gap_y_hold", int'(if0.y), 1);

      step(1, 0, 0, 0);
      repeat (5) foreach (s_pat[i]) step(0, s_pat[i][0], 1, 0);
      settle();
      dchk("sat_count", int'(if3.count), 3);
      step(0, 1, 1, 0);
      step(0, 0, 1, 0);
      step(0, 1, 1, 0);
      step(0, 1, 1, 1);
      settle();
      dchk("clr_on_match", int'(if3.count), 1);

      step(1, 0, 0, 0);
      step(0, 1, 1, 0);
      step(0, 0, 1, 0);
      step(0, 1, 1, 0);
      settle();
      dchk("pre_rst_state", int'(if0.state), 3);
      step(1, 1, 1, 0);
      settle();
      dchk("mid_rst_state", int'(if0.state), 0);
      dchk("mid_rst_y", int'(if0.y), 0);
      step(0, 1, 1, 0);
      settle();
      dchk("post_rst_state", int'(if0.state), 1);
      dchk("post_rst_y", int'(if0.y), 0);

      repeat (800) begin
         step(($urandom_range(99, 0) == 0),
              1'($urandom_range(1, 0)),
              ($urandom_range(9, 0) < 8),
              ($urandom_range(29, 0) == 0));
      end

      wait_cnt = 0;
      while ((sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()) != 0
             && wait_cnt < 20) begin
         @(posedge clk);
         wait_cnt++;
      end
      #3;
      if ((sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()) != 0) begin
         errors++;
         $display("FAIL drain: scoreboard entries left %0d, expected 0",
                  sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
